masku_operand_aligner: RTL

MASKU_OPERAND_ALIGNER -- requirements
Module: masku_operand_aligner

---
 rtl/masku_operand_aligner_if.sv | 38 +++
 rtl/masku_operand_aligner.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/masku_operand_aligner_if.sv
// Handshake and data bundle between operand lanes, instruction issue and the mask unit.
// Slave is the aligner. Master is whoever drives instructions and operands and consumes the aligned beats.
interface masku_operand_aligner_if #(
    parameter int NrLanes    = 1,
    parameter int NrOperands = 5,
    parameter int ELEN       = 64
);
    logic                                          insn_valid_i;
    logic                                          insn_ready_o;
    logic [15:0]                                   insn_beats_i;
    logic [NrOperands-1:0]                         insn_req_ops_i;

    logic [NrLanes-1:0][NrOperands-1:0][ELEN-1:0]  opnd_i;
    logic [NrLanes-1:0][NrOperands-1:0]            opnd_valid_i;
    logic [NrLanes-1:0][NrOperands-1:0]            opnd_ready_o;

    logic [NrLanes-1:0][NrOperands-1:0][ELEN-1:0]  masku_operands_o;
    logic                                          masku_valid_o;
    logic                                          masku_ready_i;

    logic                                          insn_done_o;
    logic                                          flush_i;
    logic [31:0]                                   stall_cycles_o;

    modport slave (
        input  insn_valid_i, insn_beats_i, insn_req_ops_i,
        input  opnd_i, opnd_valid_i, masku_ready_i, flush_i,
        output insn_ready_o, opnd_ready_o, masku_operands_o, masku_valid_o,
        output insn_done_o, stall_cycles_o
    );

    modport master (
        output insn_valid_i, insn_beats_i, insn_req_ops_i,
        output opnd_i, opnd_valid_i, masku_ready_i, flush_i,
        input  insn_ready_o, opnd_ready_o, masku_operands_o, masku_valid_o,
        input  insn_done_o, stall_cycles_o
    );
endinterface

// File: rtl/masku_operand_aligner.sv
// Purpose: buffer per-(lane, slot) operands and release them to the mask unit as lane-aligned beats.
// Latency: a word is visible one cycle after it is pushed. insn_done_o is asserted one cycle after the last beat pops.
// Backpressure: opnd_ready_o is low on a full slot FIFO, and masku_ready_i low holds every FIFO.
// Optional macro MASKU_ALIGNER_STALL_CNT_EN adds the starved-cycle counter behind stall_cycles_o.

module masku_aligner_fifo #(
    parameter int Depth = 2,
    parameter int Width = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [Width-1:0] head_o
);
    localparam int AddrW = (Depth > 1) ? $clog2(Depth) : 1;

    // Extra MSB on each pointer tells full from empty when the indices match.
    logic [AddrW:0]   wr_ptr_q, rd_ptr_q;
    logic [Width-1:0] mem_q [Depth];

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                     (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
    assign head_o  = mem_q[rd_ptr_q[AddrW-1:0]];

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i && !full_o) begin
                wr_ptr_q <= wr_ptr_q + (AddrW+1)'(1);
            end
            if (pop_i && !empty_o) begin
                rd_ptr_q <= rd_ptr_q + (AddrW+1)'(1);
            end
        end
    end

    // Storage is not reset. Contents past the pointers are never observed.
    always_ff @(posedge clk_i) begin
        if (push_i && !full_o) begin
            mem_q[wr_ptr_q[AddrW-1:0]] <= data_i;
        end
    end
endmodule

module masku_operand_aligner #(
    parameter int NrLanes      = 0,
    parameter int NrMaskFUnits = 2,
    parameter int NrOperands   = NrMaskFUnits + 3,
    parameter int Depth        = 2,
    parameter int ELEN         = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    masku_operand_aligner_if.slave bus
);
    // An unset lane count (0) builds as a single lane.
    localparam int Lanes = (NrLanes > 0) ? NrLanes : 1;

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_e;

    state_e                  state_q, state_d;
    logic [15:0]             beat_cnt_q, beat_cnt_d;
    logic [NrOperands-1:0]   req_mask_q, req_mask_d;
    logic                    done_q, done_d;

    logic [Lanes-1:0][NrOperands-1:0]            full, empty;
    logic [Lanes-1:0][NrOperands-1:0][ELEN-1:0]  head;
    logic [NrOperands-1:0]                       pop;
    logic                                        all_present;
    logic                                        fire;

    assign fire = bus.masku_valid_o && bus.masku_ready_i;
    assign pop  = {NrOperands{fire}} & req_mask_q;

    for (genvar l = 0; l < Lanes; l++) begin : g_lane
        for (genvar s = 0; s < NrOperands; s++) begin : g_slot
            masku_aligner_fifo #(
                .Depth (Depth),
                .Width (ELEN)
            ) i_fifo (
                .clk_i   (clk_i),
                .rst_i   (rst_i),
                .flush_i (bus.flush_i),
                .push_i  (bus.opnd_valid_i[l][s]),
                .data_i  (bus.opnd_i[l][s]),
                .pop_i   (pop[s]),
                .full_o  (full[l][s]),
                .empty_o (empty[l][s]),
                .head_o  (head[l][s])
            );

            // Ready depends only on the registered full flag, so a full FIFO refuses a push even while popping.
            assign bus.opnd_ready_o[l][s]     = ~full[l][s];
            assign bus.masku_operands_o[l][s] = req_mask_q[s] ? head[l][s] : '0;
        end
    end

    always_comb begin
        all_present = 1'b1;
        for (int l = 0; l < Lanes; l++) begin
            for (int s = 0; s < NrOperands; s++) begin
                if (req_mask_q[s] && empty[l][s]) begin
                    all_present = 1'b0;
                end
            end
        end
    end

    assign bus.masku_valid_o = (state_q == ACTIVE) && all_present;
    assign bus.insn_ready_o  = (state_q == IDLE);
    assign bus.insn_done_o   = done_q;

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        req_mask_d = req_mask_q;
        done_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                // A zero-beat instruction is not legal, so it is dropped rather than starting an endless wait.
                if (bus.insn_valid_i && (bus.insn_beats_i != 16'd0)) begin
                    state_d    = ACTIVE;
                    beat_cnt_d = bus.insn_beats_i;
                    req_mask_d = bus.insn_req_ops_i;
                end
            end
            ACTIVE: begin
                if (fire) begin
                    beat_cnt_d = beat_cnt_q - 16'd1;
                    if (beat_cnt_q == 16'd1) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (bus.flush_i) begin
            state_d    = IDLE;
            beat_cnt_d = '0;
            req_mask_d = '0;
            done_d     = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            req_mask_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            req_mask_q <= req_mask_d;
            done_q     <= done_d;
        end
    end

`ifdef MASKU_ALIGNER_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || bus.flush_i) begin
            stall_cnt_q <= '0;
        end else if ((state_q == ACTIVE) && !bus.masku_valid_o && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign bus.stall_cycles_o = stall_cnt_q;
`else
    assign bus.stall_cycles_o = '0;
`endif
endmodule
